// File: rtl/mips_io_port_pkg.sv
// Shared definitions for the MIPS memory-mapped I/O port: register map,
// STATUS bit positions and the address-window decode helper.
package mips_io_port_pkg;

  // Word index (Address[4:2]) of each register in the window
  typedef enum logic [2:0] {
    REG_PORT_OUT  = 3'd0,
    REG_PORT_IN   = 3'd1,
    REG_STATUS    = 3'd2,
    REG_TMR_LOAD  = 3'd3,
    REG_TMR_COUNT = 3'd4
  } io_reg_e;

  // Byte offsets from the window base
  localparam logic [4:0] OFF_PORT_OUT  = 5'h00;
  localparam logic [4:0] OFF_PORT_IN   = 5'h04;
  localparam logic [4:0] OFF_STATUS    = 5'h08;
  localparam logic [4:0] OFF_TMR_LOAD  = 5'h0C;
  localparam logic [4:0] OFF_TMR_COUNT = 5'h10;

  // STATUS bit indices
  localparam int unsigned CHG_BIT  = 0;
  localparam int unsigned DONE_BIT = 1;

  // True when the upper address bits match the base and the word index is 0..4
  function automatic logic window_hit(logic [26:0] addr_hi, logic [26:0] base_hi,
                                      logic [2:0] word);
    return (addr_hi == base_hi) && (word <= 3'd4);
  endfunction

endpackage

// File: rtl/mips_io_port_if.sv
// Core data-memory bus as seen by the I/O port. The core drives the master
// side; the peripheral answers on the slave side.
interface mips_io_port_if;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic        IOSelect;
  logic [31:0] ReadData;

  modport master (
    output Address, WriteData, MemWrite, MemRead,
    input  IOSelect, ReadData
  );

  modport slave (
    input  Address, WriteData, MemWrite, MemRead,
    output IOSelect, ReadData
  );
endinterface

// File: rtl/mips_io_port_io_sync2.sv
// Async-reset two-flop synchroniser. The first stage is exposed so callers
// can detect a change on the same edge the synchronised value updates.
module io_sync2 #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] meta,
  output logic [W-1:0] q
);

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mips_io_port.sv
// Memory-mapped I/O peripheral for the single-cycle MIPS core: output latch,
// synchronised input with sticky change flag, and a one-shot down-counter.
module mips_io_port
  import mips_io_port_pkg::*;
#(
  parameter logic [31:0] IO_BASE  = 32'h1001_0020,
  parameter int unsigned IN_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  mips_io_port_if.slave       bus,
  input  logic [IN_WIDTH-1:0] PortIn,
  output logic [31:0]         PortOut
);

  logic                hit;
  io_reg_e             sel;
  logic                reg_we;
  logic                reg_re;
  logic [1:0]          unused_byte_lane;
  logic [IN_WIDTH-1:0] in_meta;
  logic [IN_WIDTH-1:0] in_sync;
  logic                chg;
  logic                done;
  logic                chg_evt;
  logic                done_evt;
  logic                status_rd;
  logic                load_we;
  logic [31:0]         load_reg;
  logic [31:0]         cnt;
  logic [31:0]         status_word;
  logic [31:0]         read_data;

  assign hit              = window_hit(bus.Address[31:5], IO_BASE[31:5], bus.Address[4:2]);
  assign sel              = io_reg_e'(bus.Address[4:2]);
  assign unused_byte_lane = bus.Address[1:0];
  assign reg_we           = hit & bus.MemWrite;
  assign reg_re           = hit & bus.MemRead;
  assign status_rd        = reg_re && (sel == REG_STATUS);
  assign load_we          = reg_we && (sel == REG_TMR_LOAD);

  io_sync2 #(.W(IN_WIDTH)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (PortIn),
    .meta  (in_meta),
    .q     (in_sync)
  );

  // meta != q is exactly "next in_sync differs from current in_sync", so CHG
  // rises on the same edge the new value appears on PORT_IN.
  assign chg_evt  = (in_meta != in_sync);
  // A load on the terminal edge takes priority and suppresses DONE.
  assign done_evt = !load_we && (cnt == 32'd1);

  // Output latch
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      PortOut <= '0;
    else if (reg_we && (sel == REG_PORT_OUT))
      PortOut <= bus.WriteData;
  end

  // One-shot down-counter; a load restarts it, zero holds
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_reg <= '0;
      cnt      <= '0;
    end else if (load_we) begin
      load_reg <= bus.WriteData;
      cnt      <= bus.WriteData;
    end else if (cnt != '0) begin
      cnt <= cnt - 32'd1;
    end
  end

  // Sticky status flags: set events beat the read-clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chg  <= 1'b0;
      done <= 1'b0;
    end else begin
      if (chg_evt)
        chg <= 1'b1;
      else if (status_rd)
        chg <= 1'b0;
      if (done_evt)
        done <= 1'b1;
      else if (status_rd)
        done <= 1'b0;
    end
  end

  // STATUS word assembly
  always_comb begin
    status_word           = '0;
    status_word[CHG_BIT]  = chg;
    status_word[DONE_BIT] = done;
  end

  // Combinational register read mux; zero outside the window
  always_comb begin
    read_data = '0;
    if (hit) begin
      case (sel)
        REG_PORT_OUT:  read_data = PortOut;
        REG_PORT_IN:   read_data = 32'(in_sync);
        REG_STATUS:    read_data = status_word;
        REG_TMR_LOAD:  read_data = load_reg;
        REG_TMR_COUNT: read_data = cnt;
        default:       read_data = '0;
      endcase
    end
  end

  assign bus.ReadData = read_data;
  assign bus.IOSelect = hit;

endmodule

// File: tb/tb_mips_io_port.sv
// Directed testbench for mips_io_port: register map, input synchroniser,
// timer and the simultaneous-event priorities.
module tb_mips_io_port;
  import mips_io_port_pkg::*;

  localparam logic [31:0] A_OUT = 32'h1001_0020;
  localparam logic [31:0] A_IN  = 32'h1001_0024;
  localparam logic [31:0] A_ST  = 32'h1001_0028;
  localparam logic [31:0] A_LD  = 32'h1001_002C;
  localparam logic [31:0] A_CNT = 32'h1001_0030;

  logic        clk;
  logic        reset;
  logic [7:0]  port_in;
  logic [31:0] port_out;
  int unsigned tests_run;
  int unsigned tests_failed;

  mips_io_port_if bus ();

  mips_io_port #(.IO_BASE(32'h1001_0020), .IN_WIDTH(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .PortIn  (port_in),
    .PortOut (port_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sw(input logic [31:0] addr, input logic [31:0] data);
    bus.Address   = addr;
    bus.WriteData = data;
    bus.MemWrite  = 1'b1;
    bus.MemRead   = 1'b0;
    tick();
    bus.MemWrite  = 1'b0;
  endtask

  // Combinational look without a read strobe (no side effects)
  task automatic peek(input logic [31:0] addr, output logic [31:0] data);
    bus.Address  = addr;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    #1;
    data = bus.ReadData;
  endtask

  // Real load: data sampled before the edge, side effects at the edge
  task automatic lw(input logic [31:0] addr, output logic [31:0] data);
    bus.Address  = addr;
    bus.MemRead  = 1'b1;
    bus.MemWrite = 1'b0;
    #1;
    data = bus.ReadData;
    @(posedge clk);
    #1;
    bus.MemRead = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    tick();
    tests_run++;
    if (port_out !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_portout got %h expected %h", port_out, 32'h0);
    end
    reset = 1'b0;
    tick();
    peek(A_ST, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_status got %h expected %h", d, 32'h0);
    end
    peek(A_CNT, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_count got %h expected %h", d, 32'h0);
    end
    tests_run++;
    if (bus.IOSelect !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ioselect got %b expected %b", bus.IOSelect, 1'b1);
    end
  endtask

  task automatic test_port_out();
    logic [31:0] d;
    sw(A_OUT, 32'h0000_00A5);
    tests_run++;
    if (port_out !== 32'h0000_00A5) begin
      tests_failed++;
      $display("FAIL portout_write got %h expected %h", port_out, 32'h0000_00A5);
    end
    lw(A_OUT, d);
    tests_run++;
    if (d !== 32'h0000_00A5) begin
      tests_failed++;
      $display("FAIL portout_read got %h expected %h", d, 32'h0000_00A5);
    end
    peek(A_OUT + 32'd3, d);
    tests_run++;
    if (d !== 32'h0000_00A5) begin
      tests_failed++;
      $display("FAIL byte_lane_ignored got %h expected %h", d, 32'h0000_00A5);
    end
    peek(32'h1001_0034, d);
    tests_run++;
    if (bus.IOSelect !== 1'b0 || d !== 32'h0) begin
      tests_failed++;
      $display("FAIL window_0x14 got sel=%b data=%h expected sel=0 data=0", bus.IOSelect, d);
    end
    peek(32'h1001_003C, d);
    tests_run++;
    if (bus.IOSelect !== 1'b0) begin
      tests_failed++;
      $display("FAIL window_0x1C got %b expected %b", bus.IOSelect, 1'b0);
    end
    peek(32'h1001_0040, d);
    tests_run++;
    if (bus.IOSelect !== 1'b0) begin
      tests_failed++;
      $display("FAIL window_next_base got %b expected %b", bus.IOSelect, 1'b0);
    end
    peek(32'h1001_0010, d);
    tests_run++;
    if (bus.IOSelect !== 1'b0) begin
      tests_failed++;
      $display("FAIL window_below_base got %b expected %b", bus.IOSelect, 1'b0);
    end
  endtask

  task automatic test_port_in();
    logic [31:0] d;
    port_in = 8'h3C;
    tick();
    peek(A_IN, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL portin_edge1 got %h expected %h", d, 32'h0);
    end
    peek(A_ST, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL chg_edge1 got %h expected %h", d, 32'h0);
    end
    tick();
    peek(A_IN, d);
    tests_run++;
    if (d !== 32'h0000_003C) begin
      tests_failed++;
      $display("FAIL portin_edge2 got %h expected %h", d, 32'h0000_003C);
    end
    lw(A_ST, d);
    tests_run++;
    if (d !== 32'h1) begin
      tests_failed++;
      $display("FAIL chg_read got %h expected %h", d, 32'h1);
    end
    lw(A_ST, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL chg_cleared got %h expected %h", d, 32'h0);
    end
  endtask

  task automatic test_timer();
    logic [31:0] d;
    logic [31:0] exp_cnt [4];
    exp_cnt = '{32'd3, 32'd2, 32'd1, 32'd0};
    sw(A_LD, 32'd3);
    for (int i = 0; i < 4; i++) begin
      peek(A_CNT, d);
      tests_run++;
      if (d !== exp_cnt[i]) begin
        tests_failed++;
        $display("FAIL timer_count[%0d] got %h expected %h", i, d, exp_cnt[i]);
      end
      if (i < 3) tick();
    end
    tick();
    peek(A_ST, d);
    tests_run++;
    if (d !== 32'h2) begin
      tests_failed++;
      $display("FAIL timer_done_held got %h expected %h", d, 32'h2);
    end
    peek(A_CNT, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL timer_no_wrap got %h expected %h", d, 32'h0);
    end
    peek(A_LD, d);
    tests_run++;
    if (d !== 32'd3) begin
      tests_failed++;
      $display("FAIL timer_load_readback got %h expected %h", d, 32'd3);
    end
    lw(A_ST, d);
    tests_run++;
    if (d !== 32'h2) begin
      tests_failed++;
      $display("FAIL timer_done_read got %h expected %h", d, 32'h2);
    end
    // Load while running, then stop with a load of 0
    sw(A_LD, 32'd5);
    tick();
    sw(A_LD, 32'd0);
    repeat (6) tick();
    peek(A_ST, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL timer_load0_no_done got %h expected %h", d, 32'h0);
    end
    // Load 1: DONE on the following edge
    sw(A_LD, 32'd1);
    peek(A_ST, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL timer_load1_pre got %h expected %h", d, 32'h0);
    end
    tick();
    lw(A_ST, d);
    tests_run++;
    if (d !== 32'h2) begin
      tests_failed++;
      $display("FAIL timer_load1_done got %h expected %h", d, 32'h2);
    end
    // Max load counts down without wrapping
    sw(A_LD, 32'hFFFF_FFFF);
    tick();
    peek(A_CNT, d);
    tests_run++;
    if (d !== 32'hFFFF_FFFE) begin
      tests_failed++;
      $display("FAIL timer_max got %h expected %h", d, 32'hFFFF_FFFE);
    end
    sw(A_LD, 32'd0);
  endtask

  task automatic test_status_race();
    logic [31:0] d;
    sw(A_LD, 32'd2);
    tick();
    lw(A_ST, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL race_read_value got %h expected %h", d, 32'h0);
    end
    peek(A_ST, d);
    tests_run++;
    if (d !== 32'h2) begin
      tests_failed++;
      $display("FAIL race_set_wins got %h expected %h", d, 32'h2);
    end
    lw(A_ST, d);
  endtask

  task automatic test_load_race();
    logic [31:0] d;
    sw(A_LD, 32'd2);
    tick();
    sw(A_LD, 32'd7);
    peek(A_CNT, d);
    tests_run++;
    if (d !== 32'd7) begin
      tests_failed++;
      $display("FAIL load_race_count got %h expected %h", d, 32'd7);
    end
    peek(A_ST, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL load_race_no_done got %h expected %h", d, 32'h0);
    end
    sw(A_IN, 32'h0000_00FF);
    peek(A_IN, d);
    tests_run++;
    if (d !== 32'h0000_003C) begin
      tests_failed++;
      $display("FAIL ro_write_ignored got %h expected %h", d, 32'h0000_003C);
    end
    tests_run++;
    if (port_out !== 32'h0000_00A5) begin
      tests_failed++;
      $display("FAIL ro_write_portout got %h expected %h", port_out, 32'h0000_00A5);
    end
  endtask

  task automatic test_read_write_both();
    logic [31:0] d;
    bus.Address   = A_OUT;
    bus.WriteData = 32'h0000_005A;
    bus.MemWrite  = 1'b1;
    bus.MemRead   = 1'b1;
    #1;
    d = bus.ReadData;
    tests_run++;
    if (d !== 32'h0000_00A5) begin
      tests_failed++;
      $display("FAIL rw_both_pre got %h expected %h", d, 32'h0000_00A5);
    end
    tick();
    bus.MemWrite = 1'b0;
    bus.MemRead  = 1'b0;
    tests_run++;
    if (port_out !== 32'h0000_005A) begin
      tests_failed++;
      $display("FAIL rw_both_write got %h expected %h", port_out, 32'h0000_005A);
    end
  endtask

  task automatic test_reset_midcount();
    logic [31:0] d;
    sw(A_LD, 32'd8);
    repeat (3) tick();
    peek(A_CNT, d);
    tests_run++;
    if (d !== 32'd5) begin
      tests_failed++;
      $display("FAIL midreset_pre_count got %h expected %h", d, 32'd5);
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if (port_out !== 32'h0) begin
      tests_failed++;
      $display("FAIL midreset_portout got %h expected %h", port_out, 32'h0);
    end
    peek(A_CNT, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL midreset_count got %h expected %h", d, 32'h0);
    end
    peek(A_IN, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL midreset_portin got %h expected %h", d, 32'h0);
    end
    tick();
    reset = 1'b0;
    tick();
    peek(A_ST, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL midreset_no_done got %h expected %h", d, 32'h0);
    end
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    reset         = 1'b1;
    port_in       = 8'h00;
    bus.Address   = '0;
    bus.WriteData = '0;
    bus.MemWrite  = 1'b0;
    bus.MemRead   = 1'b0;
    test_reset();
    test_port_out();
    test_port_in();
    test_timer();
    test_status_race();
    test_load_race();
    test_read_write_both();
    test_reset_midcount();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
